// File: rtl/decode_scoreboard.sv
// decode_scoreboard: decode-stage hazard controller.
// Tracks outstanding register writes per architectural register, stalls decode
// on RAW hazards whose producer is not yet forwardable (or when a register has
// too many writes in flight), and steers the operand muxes to the bypass path.
module decode_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_ID_W     = 5,
    parameter int ALU_LAT      = 1,
    parameter int LOAD_LAT     = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [REG_ID_W-1:0] dec_rs1,
    input  logic [REG_ID_W-1:0] dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic [REG_ID_W-1:0] dec_rd,
    input  logic                dec_wr,
    input  logic                dec_is_load,
    input  logic                ex_ready,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_ID_W-1:0] wb_rd,
    output logic                stall,
    output logic                issue,
    output logic                fwd_rs1,
    output logic                fwd_rs2,
    output logic [31:0]         stall_count,
    output logic                sb_error
);

    // Countdown reload values: a producer is forwardable once its count hits 0.
    localparam logic [1:0] ALU_CNT  = 2'(ALU_LAT - 1);
    localparam logic [1:0] LOAD_CNT = 2'(LOAD_LAT - 1);
    localparam logic [1:0] MAX_PEND = 2'(MAX_INFLIGHT);

    logic [1:0]  pend_q [NUM_REGS];
    logic [1:0]  pend_d [NUM_REGS];
    logic [1:0]  cnt_q  [NUM_REGS];
    logic [1:0]  cnt_d  [NUM_REGS];
    logic [31:0] stall_count_q, stall_count_d;
    logic        sb_error_q, sb_error_d;

    logic busy_rs1, busy_rs2, cnt_nz_rs1, cnt_nz_rs2;
    logic raw1, raw2, fwd1, fwd2, full;
    logic stall_int, issue_int;

    // Hazard decision from start-of-cycle state only (no same-cycle wb bypass).
    always_comb begin
        busy_rs1   = (pend_q[dec_rs1] != 2'd0);
        busy_rs2   = (pend_q[dec_rs2] != 2'd0);
        cnt_nz_rs1 = (cnt_q[dec_rs1] != 2'd0);
        cnt_nz_rs2 = (cnt_q[dec_rs2] != 2'd0);
        raw1       = dec_use_rs1 & busy_rs1 & cnt_nz_rs1;
        raw2       = dec_use_rs2 & busy_rs2 & cnt_nz_rs2;
        fwd1       = dec_use_rs1 & busy_rs1 & ~cnt_nz_rs1;
        fwd2       = dec_use_rs2 & busy_rs2 & ~cnt_nz_rs2;
        full       = dec_wr & (dec_rd != '0) & (pend_q[dec_rd] == MAX_PEND);
        // Reset forces every handshake output low regardless of decode inputs.
        stall_int  = ~reset & dec_valid & ~flush & (raw1 | raw2 | full | ~ex_ready);
        issue_int  = ~reset & dec_valid & ~flush & ~stall_int;
        stall      = stall_int;
        issue      = issue_int;
        fwd_rs1    = ~reset & fwd1 & dec_valid;
        fwd_rs2    = ~reset & fwd2 & dec_valid;
    end

    // Next-state for the per-register scoreboard, stall counter and error flag.
    always_comb begin
        sb_error_d    = sb_error_q |
                        (wb_en & (wb_rd != '0) & (pend_q[wb_rd] == 2'd0));
        stall_count_d = stall_count_q + 32'(stall_int);
        pend_d[0]     = 2'd0;
        cnt_d[0]      = 2'd0;
        for (int r = 1; r < NUM_REGS; r++) begin
            logic iss_hit;
            logic wb_hit;
            iss_hit   = issue_int & dec_wr & (dec_rd == REG_ID_W'(r));
            // A writeback against an empty entry is an error and changes nothing.
            wb_hit    = wb_en & (wb_rd == REG_ID_W'(r)) & (pend_q[r] != 2'd0);
            pend_d[r] = pend_q[r];
            cnt_d[r]  = cnt_q[r];
            if (iss_hit && !wb_hit) begin
                pend_d[r] = pend_q[r] + 2'd1;
            end else if (!iss_hit && wb_hit) begin
                pend_d[r] = pend_q[r] - 2'd1;
            end
            // The youngest writer's latency always wins; draining clears the count.
            if (iss_hit) begin
                cnt_d[r] = dec_is_load ? LOAD_CNT : ALU_CNT;
            end else if (wb_hit && (pend_q[r] == 2'd1)) begin
                cnt_d[r] = 2'd0;
            end else if ((pend_q[r] != 2'd0) && (cnt_q[r] != 2'd0)) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= 2'd0;
                cnt_q[r]  <= 2'd0;
            end
            stall_count_q <= 32'd0;
            sb_error_q    <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
            sb_error_q    <= sb_error_d;
        end
    end

    assign stall_count = stall_count_q;
    assign sb_error    = sb_error_q;

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Hazard controller for the decode stage. Tracks in-flight register writes with a per-register scoreboard.
- Stalls decode on RAW hazards whose result is not yet forwardable. Tells the operand muxes when to take the bypass path instead of register file read data.
- Sits between decode and execute. Issue is gated by execute readiness and flush; writeback retires entries.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired and never tracked.
- REG_ID_W, 5, register id width.
- ALU_LAT, 1, cycles from issue until an ALU result is forwardable; range 1..4.
- LOAD_LAT, 2, cycles from issue until a load result is forwardable; range 1..4.
- MAX_INFLIGHT, 3, maximum outstanding writes per register; range 1..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1  in  REG_ID_W  source register 1 id.
- dec_rs2  in  REG_ID_W  source register 2 id.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_rd  in  REG_ID_W  destination register id.
- dec_wr  in  1  instruction writes rd.
- dec_is_load  in  1  rd is produced by a load.
- ex_ready  in  1  execute stage can accept an instruction this cycle.
- flush  in  1  kill the instruction in decode.
- wb_en  in  1  writeback commits a register this cycle.
- wb_rd  in  REG_ID_W  register id committed at writeback.
- stall  out  1  decode must hold (combinational).
- issue  out  1  instruction moves to execute this cycle (combinational).
- fwd_rs1  out  1  rs1 must take the bypass value.
- fwd_rs2  out  1  rs2 must take the bypass value.
- stall_count  out  32  count of cycles in which stall was high.
- sb_error  out  1  sticky flag: writeback arrived with no pending write.

Behaviour:
- Per-register state for r = 1..NUM_REGS-1:
  - pend[r]: 2-bit outstanding-write count.
  - cnt[r]: 2-bit cycles until the youngest writer becomes forwardable.
  - busy[r] = (pend[r] != 0).
- Reset: every pend and cnt is 0; stall_count is 0; sb_error is 0. During reset, stall, issue, fwd_rs1 and fwd_rs2 are 0 regardless of inputs.
- Register 0 is never busy. Issue or writeback with id 0 leaves all state unchanged.
- raw1 = dec_use_rs1 & busy[rs1] & (cnt[rs1] != 0). raw2 is the same form on rs2.
- fwd1 = dec_use_rs1 & busy[rs1] & (cnt[rs1] == 0). fwd2 is the same form on rs2.
- full = dec_wr & (dec_rd != 0) & (pend[rd] == MAX_INFLIGHT).
- stall = dec_valid & ~flush & (raw1 | raw2 | full | ~ex_ready).
- issue = dec_valid & ~flush & ~stall.
- fwd_rs1 = fwd1 & dec_valid; fwd_rs2 = fwd2 & dec_valid. These are valid in the issue cycle only.
- Hazard evaluation uses state registered at the start of the cycle. No same-cycle bypass from wb into the stall decision.
- On issue with dec_wr and rd != 0:
  - pend[rd] increments.
  - cnt[rd] loads (dec_is_load ? LOAD_LAT : ALU_LAT) - 1, overriding any decrement that cycle.
- Every other busy register with cnt != 0 decrements cnt by 1 each cycle.
- On wb_en with wb_rd != 0:
  - If pend[wb_rd] != 0, pend decrements.
  - If pend[wb_rd] == 0, state is unchanged and sb_error is set.
  - When pend reaches 0, cnt is forced to 0.
- Issue and writeback to the same rd in the same cycle: pend is unchanged (+1 -1) and cnt loads the new writer's latency.
- Writebacks are in program order, so the youngest writer's cnt alone governs forwarding.
- flush: issue is 0 and stall is 0 that cycle. Scoreboard state is unaffected, because in-flight writers are older and still retire. Decrements and writebacks proceed normally.
- stall_count increments by 1 in each cycle with stall = 1 and wraps from 0xFFFFFFFF to 0.
- sb_error clears only on reset.
- Reset asserted mid-operation: all state clears on that edge. Writebacks for pre-reset instructions then arrive against pend = 0, set sb_error, and are otherwise ignored.

Test Plan:
- Load then dependent use: issue load to x5 (LOAD_LAT=2), next cycle decode rs1=x5 -> stall=1 for 1 cycle, then issue=1 with fwd_rs1=1; stall_count=1.
- Back-to-back ALU: issue add x3, next cycle decode rs2=x3 -> stall=0, issue=1, fwd_rs2=1; after wb_rd=3, pend[3]=0 and a read of x3 gives fwd_rs2=0.
- x0 handling: issue a write to x0, then decode rs1=x0 -> stall=0, fwd_rs1=0; wb_rd=0 leaves sb_error=0.
- WAW saturation (MAX_INFLIGHT=3): three ALU writes to x7 with no wb, fourth decode writing x7 -> stall=1 until wb_rd=7, then issue=1.
- Simultaneous issue and wb on x9 with pend=1: pend stays 1 and cnt reloads. Flush with a RAW-hazard decode -> stall=0, issue=0, state unchanged.
- Spurious wb: wb_rd=4 with pend[4]=0 -> sb_error=1 and remains 1. Reset mid-sequence -> all outputs 0 and stall_count=0.
